// File: rtl/pipe_stage_ctrl.sv
// Pipeline stage controller: warm-up, load-use stall, branch flush and halt/drain.
// Optional load-use stall counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_ctrl #(
  parameter int WARMUP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  ex_rt,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        halt_req,
  input  logic        resume,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_clr,
  output logic        idex_clr,
  output logic [2:0]  stage_valid,
  output logic [2:0]  state,
  output logic [31:0] stall_count
);

  typedef enum logic [2:0] {
    WARM  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    HALT  = 3'd3
  } state_t;

  localparam logic [3:0] WARM_LAST = 4'(WARMUP_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_warm_cnt;
  logic [2:0] r_valid;
  logic       w_hazard;

  assign w_hazard = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

  // Control outputs are purely combinational; reset forces the WARM pattern.
  always_comb begin
    pc_en    = 1'b0;
    ifid_en  = 1'b0;
    ifid_clr = 1'b1;
    idex_clr = 1'b1;
    if (!reset) begin
      case (r_state)
        RUN: begin
          if (ex_branch_taken) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
          end else if (w_hazard) begin
            ifid_clr = 1'b0;
            idex_clr = 1'b1;
          end else if (halt_req) begin
            ifid_clr = 1'b1;
            idex_clr = 1'b0;
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            ifid_clr = 1'b0;
            idex_clr = 1'b0;
          end
        end
        DRAIN:   idex_clr = ex_branch_taken;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= WARM;
      r_warm_cnt <= 4'd0;
      r_valid    <= 3'b000;
    end else begin
      r_valid[0] <= ifid_clr ? 1'b0 : (ifid_en ? 1'b1 : r_valid[0]);
      r_valid[1] <= idex_clr ? 1'b0 : ((ifid_en || ifid_clr) ? r_valid[0] : 1'b0);
      r_valid[2] <= r_valid[1];
      case (r_state)
        WARM: begin
          if (r_warm_cnt == WARM_LAST) r_state <= RUN;
          else                         r_warm_cnt <= r_warm_cnt + 4'd1;
        end
        RUN: begin
          if (!ex_branch_taken && !w_hazard && halt_req) r_state <= DRAIN;
        end
        DRAIN: begin
          if (r_valid == 3'b000) r_state <= HALT;
        end
        HALT: begin
          if (resume) r_state <= RUN;
        end
        default: begin
          r_state    <= WARM;
          r_warm_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign stage_valid = r_valid;
  assign state       = r_state;

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = (r_state == RUN) && !ex_branch_taken && w_hazard;

  always_ff @(posedge clk) begin
    if (reset)                              r_stall_cnt <= 32'd0;
    else if (w_stall && r_stall_cnt != '1)  r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_count = r_stall_cnt;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Scoreboard bench for pipe_stage_ctrl: directed scenarios plus random traffic
// against a behavioural model; PIPE_STALL_CNT_EN selects the counter expectation.
module tb_pipe_stage_ctrl;

  localparam int WARMUP = 1;

  logic        clk = 1'b0;
  logic        reset, ex_mem_read, ex_branch_taken, halt_req, resume;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        pc_en, ifid_en, ifid_clr, idex_clr;
  logic [2:0]  stage_valid, state;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  pipe_stage_ctrl #(.WARMUP_CYCLES(WARMUP)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .halt_req(halt_req), .resume(resume), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_clr(ifid_clr), .idex_clr(idex_clr), .stage_valid(stage_valid),
    .state(state), .stall_count(stall_count)
  );

  typedef struct {
    logic [3:0]  ctl;   // {pc_en, ifid_en, ifid_clr, idex_clr}
    logic [2:0]  sv;
    logic [2:0]  st;
    logic [31:0] cnt;
    int          idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_cycle = 0;

  // Behavioural model: mode names, warm-up countdown, pipeline occupancy bits.
  localparam int M_WARM = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3;
  int          m_mode = M_WARM;
  int          m_warm_left = WARMUP;
  bit [2:0]    m_valid = 3'b000;
  longint      m_stalls = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, idx, act, exp);
  endtask

  task automatic step(input bit chk, input bit rst, input bit br, input bit mr,
                      input bit hr, input bit rs_, input bit [4:0] rs,
                      input bit [4:0] rt, input bit [4:0] ert);
    bit pc, ife, ifc, idc, hz;
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; ex_branch_taken = br; ex_mem_read = mr; halt_req = hr;
    resume = rs_; id_rs = rs; id_rt = rt; ex_rt = ert;
    hz = mr && ert != 0 && (ert == rs || ert == rt);
    {pc, ife, ifc, idc} = 4'b0011;
    if (!rst) begin
      if (m_mode == M_RUN) begin
        if (br)      {pc, ife, ifc, idc} = 4'b1111;
        else if (hz) {pc, ife, ifc, idc} = 4'b0001;
        else if (hr) {pc, ife, ifc, idc} = 4'b0010;
        else         {pc, ife, ifc, idc} = 4'b1100;
      end else if (m_mode == M_DRAIN) begin
        idc = br;
      end
    end
    e.ctl = {pc, ife, ifc, idc};
    e.sv  = m_valid;
    e.st  = 3'(m_mode);
`ifdef PIPE_STALL_CNT_EN
    e.cnt = 32'(m_stalls);
`else
    e.cnt = 32'd0;
`endif
    e.idx = n_cycle;
    if (chk) exp_q.push_back(e);
    n_cycle++;
    // Advance the model to what the coming edge produces.
    if (rst) begin
      m_mode = M_WARM; m_warm_left = WARMUP; m_valid = 3'b000; m_stalls = 0;
    end else begin
      bit [2:0] nv;
      nv[0] = ifc ? 1'b0 : (ife ? 1'b1 : m_valid[0]);
      nv[1] = idc ? 1'b0 : ((ife || ifc) ? m_valid[0] : 1'b0);
      nv[2] = m_valid[1];
      case (m_mode)
        M_WARM: begin
          m_warm_left--;
          if (m_warm_left == 0) m_mode = M_RUN;
        end
        M_RUN: begin
          if (!br && hz && m_stalls < 64'hFFFF_FFFF) m_stalls++;
          if (!br && !hz && hr) m_mode = M_DRAIN;
        end
        M_DRAIN: if (m_valid == 3'b000) m_mode = M_HALT;
        default: if (rs_) m_mode = M_RUN;
      endcase
      m_valid = nv;
    end
  endtask

  // Monitor: compare every DUT output set against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ctl{pc,ifen,ifclr,idclr}", e.idx, 32'({pc_en, ifid_en, ifid_clr, idex_clr}), 32'(e.ctl));
        check("stage_valid", e.idx, 32'(stage_valid), 32'(e.sv));
        check("state", e.idx, 32'(state), 32'(e.st));
        check("stall_count", e.idx, stall_count, e.cnt);
        $display("cycle %0d: state=%0d ctl=%b sv=%b stalls=%0d", e.idx, state,
                 {pc_en, ifid_en, ifid_clr, idex_clr}, stage_valid, stall_count);
      end
    end
  end

  initial begin
    reset = 1'b1; ex_branch_taken = 0; ex_mem_read = 0; halt_req = 0; resume = 0;
    id_rs = 0; id_rt = 0; ex_rt = 0;
    // Initial reset is unchecked: the DUT state is undefined before it.
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    // Reset held one checked cycle, then warm-up and running.
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 1, 2, 3);
    // Load-use hazard on rs, then rt.
    step(1, 0, 0, 1, 0, 0, 5, 1, 5);
    step(1, 0, 0, 0, 0, 0, 1, 2, 3);
    step(1, 0, 0, 1, 0, 0, 2, 9, 9);
    // Load writing r0 never stalls.
    step(1, 0, 0, 1, 0, 0, 0, 0, 0);
    // Branch and hazard together: branch wins.
    step(1, 0, 1, 1, 0, 0, 5, 5, 5);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 1, 2, 3);
    // Halt with a full pipe, drain, halt ignored in HALT, resume.
    step(1, 0, 0, 0, 1, 0, 1, 2, 3);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1, 0, 1, 2, 3);
    step(1, 0, 0, 0, 0, 1, 1, 2, 3);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 1, 2, 3);
    // Seven stalls, fill the pipe, halt, then reset while draining.
    for (int i = 0; i < 7; i++) step(1, 0, 0, 1, 0, 0, 7, 0, 7);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 1, 2, 3);
    step(1, 0, 0, 0, 1, 0, 1, 2, 3);
    step(1, 0, 0, 0, 0, 0, 1, 2, 3);
    step(1, 1, 0, 0, 0, 0, 1, 2, 3);
    step(1, 0, 0, 0, 0, 0, 1, 2, 3);
    step(1, 0, 0, 0, 0, 0, 1, 2, 3);
    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step(1, ($urandom_range(0, 63) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 7) == 0), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end
    repeat (3) @(posedge clk);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
